// File: rtl/rv_mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data access (MEM).
// Define RV_ARB_TIMEOUT_EN to add a wait-cycle watchdog that aborts a stuck access and sets err_o.
module rv_mem_arbiter #(
   parameter int unsigned AW          = 64,
   parameter int unsigned DW          = 64,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            if_req_i,
   input  logic [AW-1:0]   if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [31:0]     if_rdata_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [AW-1:0]   d_addr_i,
   input  logic [DW-1:0]   d_wdata_i,
   input  logic [DW/8-1:0] d_be_i,
   output logic            d_gnt_o,
   output logic            d_rvalid_o,
   output logic [DW-1:0]   d_rdata_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_be_o,
   input  logic            mem_ack_i,
   input  logic [DW-1:0]   mem_rdata_i,
   output logic            stall_if_o,
   output logic            stall_mem_o,
   output logic            busy_o,
   output logic            err_o
);

   typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_e;
   typedef enum logic {OWNER_IF, OWNER_D} owner_e;

   state_e            state_q, state_d;
   owner_e            last_owner_q, last_owner_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [AW-1:0]     mem_addr_q, mem_addr_d;
   logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
   logic [DW/8-1:0]   mem_be_q, mem_be_d;
   logic              if_gnt_q, if_gnt_d;
   logic              d_gnt_q, d_gnt_d;
   logic              if_pend_q, if_pend_d;
   logic              d_pend_q, d_pend_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [DW-1:0]     d_rdata_q, d_rdata_d;

   logic              arb_en;
   logic              if_excl, d_excl;
   logic              if_cand, d_cand;
   logic              if_win, d_win;

`ifdef RV_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
   logic [15:0]       wait_cnt_q, wait_cnt_d;
   logic              err_q, err_d;
   logic              timeout_hit;

   assign timeout_hit = (state_q != IDLE) && !mem_ack_i && (wait_cnt_q == TIMEOUT_LAST);
`endif

   // Completion, arbitration and grant. A requester whose response is still in flight
   // (captured, pending or pulsing rvalid) is excluded so its held request is not re-issued.
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      if_gnt_d     = 1'b0;
      d_gnt_d      = 1'b0;
      if_pend_d    = 1'b0;
      d_pend_d     = 1'b0;
      if_rvalid_d  = if_pend_q;
      d_rvalid_d   = d_pend_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      arb_en       = 1'b0;
      if_excl      = if_pend_q | if_rvalid_q;
      d_excl       = d_pend_q | d_rvalid_q;
`ifdef RV_ARB_TIMEOUT_EN
      err_d        = err_q;
      wait_cnt_d   = '0;
      if ((state_q != IDLE) && !mem_ack_i) begin
         wait_cnt_d = wait_cnt_q + 16'd1;
      end
`endif

      case (state_q)
         IDLE: begin
            arb_en = 1'b1;
         end
         IF_WAIT: begin
            if (mem_ack_i) begin
               if_pend_d  = 1'b1;
               if_rdata_d = mem_addr_q[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
               if_excl    = 1'b1;
               arb_en     = 1'b1;
            end
         end
         D_WAIT: begin
            if (mem_ack_i) begin
               d_pend_d  = 1'b1;
               d_rdata_d = mem_we_q ? '0 : mem_rdata_i;
               d_excl    = 1'b1;
               arb_en    = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef RV_ARB_TIMEOUT_EN
      // Abort: the owner gets a NOP (fetch) or zero (data) through the normal rvalid path.
      if (timeout_hit) begin
         if (state_q == IF_WAIT) begin
            if_pend_d  = 1'b1;
            if_rdata_d = 32'h0000_0013;
         end else begin
            d_pend_d  = 1'b1;
            d_rdata_d = '0;
         end
         err_d     = 1'b1;
         mem_req_d = 1'b0;
         state_d   = IDLE;
      end
`endif

      if_cand = if_req_i & ~if_excl & arb_en;
      d_cand  = d_req_i & ~d_excl & arb_en;
      d_win   = d_cand & (~if_cand | (last_owner_q == OWNER_IF));
      if_win  = if_cand & ~d_win;

      if (d_win) begin
         state_d      = D_WAIT;
         last_owner_d = OWNER_D;
         mem_req_d    = 1'b1;
         mem_we_d     = d_we_i;
         mem_addr_d   = d_addr_i;
         mem_wdata_d  = d_wdata_i;
         mem_be_d     = d_be_i;
         d_gnt_d      = 1'b1;
      end else if (if_win) begin
         state_d      = IF_WAIT;
         last_owner_d = OWNER_IF;
         mem_req_d    = 1'b1;
         mem_we_d     = 1'b0;
         mem_addr_d   = if_addr_i;
         mem_wdata_d  = '0;
         mem_be_d     = '1;
         if_gnt_d     = 1'b1;
      end else if (arb_en) begin
         mem_req_d = 1'b0;
         state_d   = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         last_owner_q <= OWNER_IF;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         if_gnt_q     <= 1'b0;
         d_gnt_q      <= 1'b0;
         if_pend_q    <= 1'b0;
         d_pend_q     <= 1'b0;
         if_rvalid_q  <= 1'b0;
         d_rvalid_q   <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         if_gnt_q     <= if_gnt_d;
         d_gnt_q      <= d_gnt_d;
         if_pend_q    <= if_pend_d;
         d_pend_q     <= d_pend_d;
         if_rvalid_q  <= if_rvalid_d;
         d_rvalid_q   <= d_rvalid_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

`ifdef RV_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

   assign if_gnt_o    = if_gnt_q;
   assign if_rvalid_o = if_rvalid_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_gnt_o     = d_gnt_q;
   assign d_rvalid_o  = d_rvalid_q;
   assign d_rdata_o   = d_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = mem_be_q;
   assign stall_if_o  = if_req_i & ~if_rvalid_q;
   assign stall_mem_o = d_req_i & ~d_rvalid_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: a memory model with programmable ack delay,
// scoreboard queues of expected read data per port, and a log of grant order.
module tb_rv_mem_arbiter;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        if_req_i = 1'b0;
   logic [63:0] if_addr_i = '0;
   logic        if_gnt_o, if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i = 1'b0;
   logic        d_we_i = 1'b0;
   logic [63:0] d_addr_i = '0;
   logic [63:0] d_wdata_i = '0;
   logic [7:0]  d_be_i = '0;
   logic        d_gnt_o, d_rvalid_o;
   logic [63:0] d_rdata_o;
   logic        mem_req_o, mem_we_o;
   logic [63:0] mem_addr_o, mem_wdata_o;
   logic [7:0]  mem_be_o;
   logic        mem_ack_i = 1'b0;
   logic [63:0] mem_rdata_i = '0;
   logic        stall_if_o, stall_mem_o, busy_o, err_o;

   always #5 clk = ~clk;

   rv_mem_arbiter #(.AW(64), .DW(64), .TIMEOUT_CYC(4)) dut (
      .clk(clk), .rstn(rstn),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
      .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i), .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   int          checks = 0;
   int          failures = 0;
   logic [63:0] ifExp[$];
   logic [63:0] dExp[$];
   bit          ownerLog[$];
   int          ackDelay = 0;
   bit          noAck = 0;
   bit          useFixed = 0;
   logic [63:0] fixedData = 64'h1111_1111_2222_2222;
   int          waitCnt = 0;
   bit          prevAck;
   bit          t2Started, t2IfGnt, t2IfDone;
   int          t2Drops, t2StallLow;
   int          t4ReqCycles, t4Unstable, t4Rvalids;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] memData(input logic [63:0] addr);
      return {~addr[31:0], addr[31:0] ^ 32'h5A5A_0F0F};
   endfunction

   function automatic logic [63:0] expFor(input bit isData, input bit we, input logic [63:0] addr);
      logic [63:0] word;
      word = memData(addr);
      if (isData) return we ? 64'd0 : word;
      return addr[2] ? {32'd0, word[63:32]} : {32'd0, word[31:0]};
   endfunction

   // Memory: acks after ackDelay non-ack wait cycles; a cycle after an ack with req still high is a new access.
   always begin
      @(posedge clk);
      #1;
      prevAck = mem_ack_i;
      if (!mem_req_o || noAck) begin
         mem_ack_i = 1'b0;
         waitCnt   = 0;
      end else begin
         if (prevAck) waitCnt = 0;
         if (waitCnt >= ackDelay) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = useFixed ? fixedData : memData(mem_addr_o);
         end else begin
            mem_ack_i = 1'b0;
            waitCnt++;
         end
      end
   end

   // Scoreboard side: grant order and returned data against expectations queued at request time.
   always @(negedge clk) begin
      if (if_gnt_o) ownerLog.push_back(1'b0);
      if (d_gnt_o) ownerLog.push_back(1'b1);
      if (if_rvalid_o) begin
         if (ifExp.size() == 0) checkOutput("if_rvalid_unexpected", 64'(if_rvalid_o), 64'd0);
         else checkOutput("if_rdata", 64'(if_rdata_o), ifExp.pop_front());
      end
      if (d_rvalid_o) begin
         if (dExp.size() == 0) checkOutput("d_rvalid_unexpected", 64'(d_rvalid_o), 64'd0);
         else checkOutput("d_rdata", d_rdata_o, dExp.pop_front());
      end
   end

   task automatic applyReset();
      rstn     = 1'b0;
      if_req_i = 1'b0;
      d_req_i  = 1'b0;
      d_we_i   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Called just after a rising edge; holds the request until rvalid, returns just after a rising edge.
   task automatic applyStimulus(input bit isData, input bit we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [7:0] be, input logic [63:0] expData);
      int n;
      if (isData) begin
         d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata; d_be_i = be;
         dExp.push_back(expData);
      end else begin
         if_req_i = 1'b1; if_addr_i = addr;
         ifExp.push_back(expData);
      end
      n = 0;
      forever begin
         @(negedge clk);
         if (isData ? d_rvalid_o : if_rvalid_o) break;
         n++;
         if (n >= 100) break;
      end
      if (n >= 100) checkOutput(isData ? "d_rvalid_wait" : "if_rvalid_wait",
                                64'(isData ? d_rvalid_o : if_rvalid_o), 64'd1);
      @(posedge clk);
      #1;
      if (isData) begin
         d_req_i = 1'b0; d_we_i = 1'b0;
      end else begin
         if_req_i = 1'b0;
      end
   endtask

   initial begin
      applyReset();
      @(negedge clk);
      checkOutput("rst_mem_req", 64'(mem_req_o), 64'd0);
      checkOutput("rst_busy", 64'(busy_o), 64'd0);
      checkOutput("rst_if_gnt", 64'(if_gnt_o), 64'd0);
      checkOutput("rst_d_rvalid", 64'(d_rvalid_o), 64'd0);
      checkOutput("rst_mem_be", 64'(mem_be_o), 64'd0);
      checkOutput("rst_err", 64'(err_o), 64'd0);

      // Single fetch with zero-wait memory: grant at T+1, rvalid at T+3.
      @(posedge clk); #1;
      useFixed = 1; ackDelay = 0;
      if_req_i = 1'b1; if_addr_i = 64'h8;
      ifExp.push_back(64'h2222_2222);
      @(negedge clk);
      checkOutput("t1_gnt_early", 64'(if_gnt_o), 64'd0);
      checkOutput("t1_stall_if", 64'(stall_if_o), 64'd1);
      @(negedge clk);
      checkOutput("t1_gnt", 64'(if_gnt_o), 64'd1);
      checkOutput("t1_mem_req", 64'(mem_req_o), 64'd1);
      checkOutput("t1_mem_addr", mem_addr_o, 64'h8);
      checkOutput("t1_mem_be", 64'(mem_be_o), 64'hFF);
      checkOutput("t1_mem_we", 64'(mem_we_o), 64'd0);
      @(negedge clk);
      checkOutput("t1_rvalid_early", 64'(if_rvalid_o), 64'd0);
      @(negedge clk);
      checkOutput("t1_rvalid", 64'(if_rvalid_o), 64'd1);
      checkOutput("t1_stall_released", 64'(stall_if_o), 64'd0);
      @(posedge clk); #1;
      if_req_i = 1'b0; useFixed = 0;
      @(negedge clk);
      checkOutput("t1_no_regrant", 64'(mem_req_o), 64'd0);

      // Conflict right after reset: data first, fetch re-granted on the ack edge.
      applyReset();
      ownerLog.delete();
      t2Started = 0; t2IfGnt = 0; t2IfDone = 0; t2Drops = 0; t2StallLow = 0;
      @(posedge clk); #1;
      fork
         applyStimulus(1'b0, 1'b0, 64'h0, 64'd0, 8'h00, expFor(1'b0, 1'b0, 64'h0));
         applyStimulus(1'b1, 1'b0, 64'h100, 64'd0, 8'hFF, expFor(1'b1, 1'b0, 64'h100));
         begin
            repeat (12) begin
               @(negedge clk);
               if (!t2IfDone && !if_rvalid_o && !stall_if_o) t2StallLow++;
               if (if_rvalid_o) t2IfDone = 1;
               if (d_gnt_o) t2Started = 1;
               if (t2Started && !t2IfGnt && !mem_req_o) t2Drops++;
               if (if_gnt_o) t2IfGnt = 1;
            end
         end
      join
      checkOutput("t2_owner_count", 64'(ownerLog.size()), 64'd2);
      if (ownerLog.size() >= 2) begin
         checkOutput("t2_first_owner_data", 64'(ownerLog[0]), 64'd1);
         checkOutput("t2_second_owner_if", 64'(ownerLog[1]), 64'd0);
      end
      checkOutput("t2_mem_req_gap", 64'(t2Drops), 64'd0);
      checkOutput("t2_stall_if_low", 64'(t2StallLow), 64'd0);
      checkOutput("t2_if_done", 64'(t2IfDone), 64'd1);

      // Both ports held continuously for three transactions each: owners alternate D,I,...
      ackDelay = 1;
      ownerLog.delete();
      @(posedge clk); #1;
      fork
         for (int i = 0; i < 3; i++) begin
            logic [63:0] a;
            a = 64'h1004 + 64'(i * 4);
            applyStimulus(1'b0, 1'b0, a, 64'd0, 8'h00, expFor(1'b0, 1'b0, a));
         end
         for (int j = 0; j < 3; j++) begin
            logic [63:0] b;
            b = 64'h2000 + 64'(j * 16);
            applyStimulus(1'b1, 1'b0, b, 64'd0, 8'hFF, expFor(1'b1, 1'b0, b));
         end
      join
      checkOutput("t3_owner_count", 64'(ownerLog.size()), 64'd6);
      for (int k = 0; k < ownerLog.size() && k < 6; k++) begin
         checkOutput("t3_owner_order", 64'(ownerLog[k]), 64'((k % 2) == 0));
      end

      // Store with a slow memory: request held stable, exactly one rvalid, zero read data.
      ackDelay = 5;
      t4ReqCycles = 0; t4Unstable = 0; t4Rvalids = 0;
      @(posedge clk); #1;
      fork
         applyStimulus(1'b1, 1'b1, 64'h40, 64'hDEAD, 8'h03, expFor(1'b1, 1'b1, 64'h40));
         begin
            repeat (14) begin
               @(negedge clk);
               if (mem_req_o) begin
                  t4ReqCycles++;
                  if (mem_addr_o !== 64'h40 || mem_wdata_o !== 64'hDEAD ||
                      mem_be_o !== 8'h03 || mem_we_o !== 1'b1) t4Unstable++;
               end
               if (d_rvalid_o) t4Rvalids++;
            end
         end
      join
      checkOutput("t4_req_cycles", 64'(t4ReqCycles), 64'd6);
      checkOutput("t4_unstable", 64'(t4Unstable), 64'd0);
      checkOutput("t4_rvalid_count", 64'(t4Rvalids), 64'd1);

      // Asynchronous reset in the middle of a data access.
      ackDelay = 0; noAck = 1;
      @(posedge clk); #1;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 64'h200;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t5_busy_before", 64'(busy_o), 64'd1);
      checkOutput("t5_req_before", 64'(mem_req_o), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      checkOutput("t5_req_async_drop", 64'(mem_req_o), 64'd0);
      checkOutput("t5_busy_after", 64'(busy_o), 64'd0);
      d_req_i = 1'b0;
      @(negedge clk);
      rstn = 1'b1; noAck = 0;
      repeat (3) @(negedge clk);
      ownerLog.delete();
      @(posedge clk); #1;
      fork
         applyStimulus(1'b0, 1'b0, 64'h30, 64'd0, 8'h00, expFor(1'b0, 1'b0, 64'h30));
         applyStimulus(1'b1, 1'b0, 64'h300, 64'd0, 8'hFF, expFor(1'b1, 1'b0, 64'h300));
      join
      checkOutput("t5_owner_count", 64'(ownerLog.size()), 64'd2);
      if (ownerLog.size() >= 1) checkOutput("t5_first_owner_data", 64'(ownerLog[0]), 64'd1);

`ifdef RV_ARB_TIMEOUT_EN
      // Fetch to a memory that never answers: aborted with a NOP and a sticky error.
      applyReset();
      noAck = 1;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 64'h4, 64'd0, 8'h00, 64'h13);
      checkOutput("t6_err_set", 64'(err_o), 64'd1);
      checkOutput("t6_mem_req_dropped", 64'(mem_req_o), 64'd0);
      repeat (5) @(negedge clk);
      checkOutput("t6_err_sticky", 64'(err_o), 64'd1);
      noAck = 0;
      applyReset();
      @(negedge clk);
      checkOutput("t6_err_cleared", 64'(err_o), 64'd0);
`endif

      repeat (4) @(negedge clk);
      checkOutput("if_sb_drained", 64'(ifExp.size()), 64'd0);
      checkOutput("d_sb_drained", 64'(dExp.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
